// File: rtl/gray_run_arbiter_if.sv
// Request/grant bundle between the two requesters and the shared Gray-counter sequencer.
// master = requester side, slave = arbiter side.
interface gray_run_arbiter_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
);
  logic [1:0]        req;
  logic [WIDTH-1:0]  start0;
  logic [WIDTH-1:0]  start1;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic              q_valid;
  logic [WIDTH-1:0]  q;

  modport master (
    output req, start0, start1, steps0, steps1,
    input  gnt, done, busy, q_valid, q
  );

  modport slave (
    input  req, start0, start1, steps0, steps1,
    output gnt, done, busy, q_valid, q
  );
endinterface

// File: rtl/gray_run_arbiter.sv
// Round-robin owner of a shared Gray counter: load start code, advance N steps, pulse done.
// Grant one edge after req in IDLE, run occupies N+2 cycles; other requester waits for IDLE.
// GRAY_RUN_ABORT_EN: dropping req[sel] during RUN abandons the run without a done pulse.
module gray_run_arbiter #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  gray_run_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              sel_q;
  logic              last_q;
  logic [STEP_W-1:0] remaining_q;
  logic [WIDTH-1:0]  q_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              busy_q;
  logic              q_valid_q;

  logic              sel_d;
  logic [WIDTH-1:0]  start_d;
  logic [STEP_W-1:0] steps_d;
  logic [WIDTH-1:0]  bin_d;
  logic [WIDTH-1:0]  bin_inc_d;
  logic [WIDTH-1:0]  q_next_d;
  logic              abort_d;

  always_comb begin
    sel_d = 1'b0;
    case (bus.req)
      2'b01:   sel_d = 1'b0;
      2'b10:   sel_d = 1'b1;
      2'b11:   sel_d = ~last_q;
      default: sel_d = 1'b0;
    endcase
    start_d = sel_d ? bus.start1 : bus.start0;
    steps_d = sel_d ? bus.steps1 : bus.steps0;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it
    bin_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_d[i] = ^(q_q >> i);
    end
    bin_inc_d = bin_d + WIDTH'(1);
    q_next_d  = bin_inc_d ^ (bin_inc_d >> 1);
  end

`ifdef GRAY_RUN_ABORT_EN
  assign abort_d = (state_q == RUN) && !bus.req[sel_q];
`else
  assign abort_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;
      remaining_q <= '0;
      q_q         <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      busy_q      <= 1'b0;
      q_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            sel_q       <= sel_d;
            q_q         <= start_d;
            remaining_q <= steps_d;
            gnt_q       <= sel_d ? 2'b10 : 2'b01;
            busy_q      <= 1'b1;
            q_valid_q   <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          if (abort_d) begin
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            q_valid_q <= 1'b0;
            last_q    <= sel_q;
            state_q   <= IDLE;
          end else if (remaining_q != '0) begin
            q_q         <= q_next_d;
            remaining_q <= remaining_q - STEP_W'(1);
          end else begin
            done_q    <= gnt_q;
            q_valid_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          gnt_q   <= 2'b00;
          done_q  <= 2'b00;
          busy_q  <= 1'b0;
          last_q  <= sel_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.q_valid = q_valid_q;
  assign bus.q       = q_q;

endmodule

// File: doc/gray_run_arbiter.md
# gray_run_arbiter

Sequencer and two-way arbiter for a shared Gray-code counter. Each requester asks for a "run": load a start code, then advance a given number of Gray steps, then release. The block owns the counter register, grants it round-robin between two requesters, and drives the load/advance sequence. Downstream logic reads the shared code on `q`.

## Interface
Parameters:
- `WIDTH`, default 4: Gray code width.
- `STEP_W`, default 4: width of the step-count fields.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req`, input, 2: run request, one bit per requester.
- `start0`, input, WIDTH: start Gray code for requester 0.
- `start1`, input, WIDTH: start Gray code for requester 1.
- `steps0`, input, STEP_W: Gray advances requested by requester 0.
- `steps1`, input, STEP_W: Gray advances requested by requester 1.
- `gnt`, output, 2: one-hot grant, held for the whole run.
- `done`, output, 2: one-cycle completion pulse to the granted requester.
- `busy`, output, 1: high whenever state is not IDLE.
- `q_valid`, output, 1: high in RUN.
- `q`, output, WIDTH: shared Gray counter value.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- All outputs are registered.
- Reset values: state IDLE, `gnt`=00, `done`=00, `busy`=0, `q_valid`=0, `q`=0.
- Reset also clears the `last` pointer to 1, so requester 0 wins the first tie.
- IDLE:
  - `req`=00: stay in IDLE; `q` holds.
  - One bit set: grant that requester.
  - Both bits set: grant the requester that is not `last`.
  - On the granting edge: `sel` is latched, `q` ← `start[sel]`, `remaining` ← `steps[sel]`, `gnt[sel]`=1, next state RUN.
- RUN:
  - `remaining` ≠ 0: `q` ← next Gray code, `remaining` decrements.
  - `remaining` = 0: `q` holds, next state DONE.
- Gray advance: convert `q` to binary, add 1 modulo 2^WIDTH, convert back to Gray. For WIDTH=4, 1000 wraps to 0000.
- DONE:
  - `done[sel]`=1 for exactly one cycle; `gnt` stays high during DONE.
  - `last` ← `sel`; next state IDLE.
  - `gnt` and `done` clear on the edge into IDLE.
- `q` holds its final value in IDLE until the next grant.
- `start`/`steps` are sampled only on the granting edge; later changes are ignored.
- Reset mid-run: immediately returns every output to its reset value. No `done` pulse.

## Timing
- Grant latency: `req` sampled high at edge E0 in IDLE → after E0, `gnt[sel]`=1 and `q`=start.
- Run of N steps: edges E1..EN each advance `q` once. Edge E(N+1) enters DONE (`done` high). Edge E(N+2) returns to IDLE.
- steps=0: `q`=start is held for one RUN cycle, then DONE.
- Total occupancy is N+2 cycles with `gnt` high, plus a minimum of one IDLE cycle between runs.
- The requester must deassert `req` in the cycle after it sees `done`. A `req` still high at the next IDLE sample is treated as a new request; round-robin still applies.
- `req` of the non-granted requester is ignored while `busy`=1. It is arbitrated at the next IDLE sample.

## Configuration
- `GRAY_RUN_ABORT_EN` defined:
  - In RUN, `req[sel]` sampled low aborts the run: next state IDLE, `gnt` cleared, no `done` pulse.
  - `q` holds its current value, and `last` ← `sel`.
- `GRAY_RUN_ABORT_EN` undefined: `req` is ignored after the grant, and every run completes with a `done` pulse.

## Test plan
- Reset asserted mid-RUN (`q`=0110) → all outputs, including `q`=0000, clear asynchronously before the next clock edge. After release, a tie grants requester 0.
- `req`=01, `start0`=0011, `steps0`=3 → `gnt`=01, then `q` = 0011, 0010, 0110, 0111 on successive edges. `done`=01 for one cycle, then IDLE with `q`=0111.
- `req`=10, `start1`=1001, `steps1`=2 → `q` = 1001, 1000, 0000 (wrap). `done`=10 once.
- `req`=11 held for back-to-back runs after reset, both with steps=1 → grants alternate 01, 10, 01. Each run is 3 cycles with `gnt` high, separated by one IDLE cycle.
- steps=0, `start0`=1111 → `q`=1111 for one RUN cycle, then `done`=01 with `q` unchanged.
- With `GRAY_RUN_ABORT_EN`: `req[0]` dropped after 2 of 5 steps → `gnt`=00 next cycle, `done` never pulses, `q` holds, and the next tie grants requester 1. Without the macro, the same stimulus completes all 5 steps and pulses `done`=01.
